// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg
// Shared definitions for the instruction sequencer and its decoder:
//   - opcode constants for the 4-bit instruction opcode
//   - SelALU codes ([3:2] ALU op, [1:0] shift control) and SelAcc source codes
//   - the 3-bit FSM state encoding (also driven on the debug 'state' port)
//   - the packed control vector produced by the decoder for the EXEC cycle
// Build option: SINGLE_STEP_EN adds the STEPWAIT state to the encoding.
package instr_sequencer_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_NOP_0 = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_MOVRS = 4'b0100;
  localparam logic [3:0] OP_MOVRD = 4'b0101;
  localparam logic [3:0] OP_JZ_P1 = 4'b0110;  // jump on Z, PC source 1
  localparam logic [3:0] OP_JZ_P0 = 4'b0111;  // jump on Z, PC source 0
  localparam logic [3:0] OP_JC_P1 = 4'b1000;  // jump on C, PC source 1
  localparam logic [3:0] OP_NOP_9 = 4'b1001;
  localparam logic [3:0] OP_JC_P0 = 4'b1010;  // jump on C, PC source 0
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_SHR   = 4'b1100;
  localparam logic [3:0] OP_LI    = 4'b1101;
  localparam logic [3:0] OP_NOP_E = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // SelALU codes: [3:2] ALU operation, [1:0] shifter control
  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SHL  = 4'b0001;
  localparam logic [3:0] ALU_SHR  = 4'b0011;

  // SelAcc codes: accumulator load source
  localparam logic [1:0] ACC_ALU = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b01;
  localparam logic [1:0] ACC_IMM = 2'b10;

  // FSM state encoding; all states share one 3-bit field
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
`ifdef SINGLE_STEP_EN
    ,
    S_STEPWAIT = 3'd5
`endif
  } state_e;

  // Control vector for one EXEC cycle
  typedef struct packed {
    logic       inc_pc;
    logic       sel_pc;
    logic       load_pc;
    logic       load_reg;
    logic       load_acc;
    logic [1:0] sel_acc;
    logic [3:0] sel_alu;
    logic       halt;
  } ctrl_t;

  // All-quiet control vector, used as the default before any decode
  function automatic ctrl_t ctrl_none();
    ctrl_t c;
    c.inc_pc   = 1'b0;
    c.sel_pc   = 1'b0;
    c.load_pc  = 1'b0;
    c.load_reg = 1'b0;
    c.load_acc = 1'b0;
    c.sel_acc  = ACC_ALU;
    c.sel_alu  = ALU_PASS;
    c.halt     = 1'b0;
    return c;
  endfunction

  // Accumulator-writing operation: select ALU/source and advance the PC
  function automatic ctrl_t ctrl_acc_op(input logic [3:0] alu, input logic [1:0] acc);
    ctrl_t c;
    c          = ctrl_none();
    c.sel_alu  = alu;
    c.sel_acc  = acc;
    c.load_acc = 1'b1;
    c.inc_pc   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/instr_sequencer_op_decode.sv
// op_decode
// Purely combinational instruction decoder. Turns the latched opcode and the
// live datapath flags into the control vector applied during EXEC.
// Ports:
//   op_q  in  4  opcode latched by the sequencer in DECODE
//   z, c  in  1  datapath zero / carry flags, sampled in the EXEC cycle
//   ctrl  out    control vector (strobes, selects, halt indication)
// Build option: none (SINGLE_STEP_EN does not affect decoding).
module op_decode
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] op_q,
  input  logic       z,
  input  logic       c,
  output ctrl_t      ctrl
);

  // Decode table; jumps pick LoadPC or IncPC so the two are never both set
  always_comb begin
    ctrl = ctrl_none();
    case (op_q)
      OP_ADD:   ctrl = ctrl_acc_op(ALU_ADD,  ACC_ALU);
      OP_SUB:   ctrl = ctrl_acc_op(ALU_SUB,  ACC_ALU);
      OP_NOR:   ctrl = ctrl_acc_op(ALU_NOR,  ACC_ALU);
      OP_MOVRS: ctrl = ctrl_acc_op(ALU_PASS, ACC_REG);
      OP_SHL:   ctrl = ctrl_acc_op(ALU_SHL,  ACC_ALU);
      OP_SHR:   ctrl = ctrl_acc_op(ALU_SHR,  ACC_ALU);
      OP_LI:    ctrl = ctrl_acc_op(ALU_PASS, ACC_IMM);
      OP_MOVRD: begin
        ctrl.load_reg = 1'b1;
        ctrl.inc_pc   = 1'b1;
      end
      // SelPC only matters when the PC is actually loaded, so it is driven
      // together with LoadPC on a taken jump and left low otherwise.
      OP_JZ_P1: begin
        ctrl.load_pc = z;
        ctrl.sel_pc  = z;
        ctrl.inc_pc  = ~z;
      end
      OP_JZ_P0: begin
        ctrl.load_pc = z;
        ctrl.inc_pc  = ~z;
      end
      OP_JC_P1: begin
        ctrl.load_pc = c;
        ctrl.sel_pc  = c;
        ctrl.inc_pc  = ~c;
      end
      OP_JC_P0: begin
        ctrl.load_pc = c;
        ctrl.inc_pc  = ~c;
      end
      OP_HALT: begin
        ctrl.halt = 1'b1;
      end
      OP_NOP_0, OP_NOP_9, OP_NOP_E: begin
        ctrl.inc_pc = 1'b1;
      end
      default: begin
        // Unreachable with a full 4-bit table; behave as a NOP if it ever is
        ctrl.inc_pc = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> FETCH,
// with a terminal HALT state left only through reset.
// Ports:
//   clk        in   system clock, rising-edge
//   CLB        in   synchronous active-low reset (priority over everything)
//   run        in   start request, looked at only in IDLE
//   Opcode     in 4 opcode from the instruction register, latched in DECODE
//   Z, C       in   datapath flags, used in EXEC
//   mem_ready  in   instruction memory data valid
//   step       in   single-step advance (only with SINGLE_STEP_EN)
//   mem_req    out  fetch request (FETCH)
//   LoadIR     out  IR load, FETCH cycle in which mem_ready is seen
//   IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc[1:0], SelALU[3:0]
//              out  datapath controls, driven only in EXEC
//   halted     out  high while in HALT
//   retired    out 8 executed-instruction counter, wraps 255 -> 0
//   state      out 3 current FSM state (debug)
// Build option: SINGLE_STEP_EN adds the step port and the STEPWAIT state,
// entered after every non-HALT EXEC and left on step=1.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       CLB,
  input  logic       run,
  input  logic [3:0] Opcode,
  input  logic       Z,
  input  logic       C,
  input  logic       mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       mem_req,
  output logic       LoadIR,
  output logic       IncPC,
  output logic       SelPC,
  output logic       LoadPC,
  output logic       LoadReg,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] SelALU,
  output logic       halted,
  output logic [7:0] retired,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] retired_q, retired_d;
  ctrl_t      ctrl_s;

  op_decode u_op_decode (
    .op_q (op_q),
    .z    (Z),
    .c    (C),
    .ctrl (ctrl_s)
  );

  // State, latched opcode and retire counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!CLB) begin
      state_q   <= S_IDLE;
      op_q      <= 4'b0000;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic, opcode capture and retire counting
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // Wait for memory indefinitely; only reset can abandon a fetch
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        op_d    = Opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // HALT counts as retired too; the 8-bit add wraps naturally
        retired_d = retired_q + 8'd1;
        if (ctrl_s.halt) begin
          state_d = S_HALT;
        end else begin
`ifdef SINGLE_STEP_EN
          state_d = S_STEPWAIT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
`ifdef SINGLE_STEP_EN
      S_STEPWAIT: begin
        if (step) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_STEPWAIT;
        end
      end
`endif
      default: begin
        // Unused encodings recover to IDLE
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: everything low except in FETCH and EXEC
  always_comb begin
    mem_req = 1'b0;
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelAcc  = 2'b00;
    SelALU  = 4'b0000;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        LoadIR  = mem_ready;
      end
      S_EXEC: begin
        IncPC   = ctrl_s.inc_pc;
        SelPC   = ctrl_s.sel_pc;
        LoadPC  = ctrl_s.load_pc;
        LoadReg = ctrl_s.load_reg;
        LoadAcc = ctrl_s.load_acc;
        SelAcc  = ctrl_s.sel_acc;
        SelALU  = ctrl_s.sel_alu;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer
// Directed + randomized bench for instr_sequencer. Inputs change on the
// falling edge, outputs are checked 1 time unit later, away from the rising
// edge. Expected controls come from a rule-level model of the instruction set.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       CLB, run, Z, C, mem_ready;
  logic [3:0] Opcode;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif
  logic       mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, halted;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [7:0] retired;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_retired = 0;
  int incpc_pulses = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .CLB(CLB), .run(run), .Opcode(Opcode), .Z(Z), .C(C),
    .mem_ready(mem_ready),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
    .SelALU(SelALU), .halted(halted), .retired(retired), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU}
  function automatic logic [12:0] out_bus();
    return {mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU};
  endfunction

  // Instruction-set rules: what the EXEC cycle must show for op / flags
  function automatic logic [12:0] ref_exec(input logic [3:0] op, input logic z, input logic c);
    logic is_jump, flag, taken, sel, halt, lreg, lacc, inc;
    logic [3:0] alu;
    logic [1:0] acc;
    is_jump = (op == 4'd6) || (op == 4'd7) || (op == 4'd8) || (op == 4'd10);
    flag    = (op == 4'd6 || op == 4'd7) ? z : c;
    taken   = is_jump && flag;
    sel     = taken && (op == 4'd6 || op == 4'd8);
    halt    = (op == 4'd15);
    lreg    = (op == 4'd5);
    lacc    = (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 4'd13});
    inc     = !halt && !taken;
    alu     = (op == 4'd1)  ? 4'b1000 : (op == 4'd2)  ? 4'b1100 :
              (op == 4'd3)  ? 4'b0100 : (op == 4'd11) ? 4'b0001 :
              (op == 4'd12) ? 4'b0011 : 4'b0000;
    acc     = (op == 4'd4) ? 2'b01 : (op == 4'd13) ? 2'b10 : 2'b00;
    return {1'b0, 1'b0, inc, sel, taken, lreg, lacc, acc, alu};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    CLB = 1'b0; run = 1'($urandom); mem_ready = 1'($urandom);
`ifdef SINGLE_STEP_EN
    step = 1'($urandom);
`endif
    @(negedge clk);
    CLB = 1'b1; run = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_state", state, S_IDLE);
    check("rst_outs", out_bus(), 13'h0);
    check("rst_retired", retired, 8'd0);
    check("rst_halted", halted, 1'b0);
    exp_retired = 0;
  endtask

  task automatic start();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'($urandom);
    #1;
    check("start_idle_state", state, S_IDLE);
    check("start_idle_outs", out_bus(), 13'h0);
  endtask

  // One full FETCH/DECODE/EXEC pass; the DUT must be entering FETCH
  task automatic exec_instr(input logic [3:0] op, input logic z, input logic c,
                            input int waits, input int hold);
    logic [12:0] exp_bus;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      mem_ready = 1'b0; run = 1'($urandom); Opcode = 4'($urandom);
      Z = 1'($urandom); C = 1'($urandom);
      #1;
      check("fetch_state", state, S_FETCH);
      check("fetch_outs", out_bus(), 13'h1000);
      check("fetch_retired", retired, exp_retired[7:0]);
    end
    @(negedge clk);
    mem_ready = 1'b1; Opcode = op; run = 1'($urandom);
    #1;
    check("fetch_rdy_state", state, S_FETCH);
    check("fetch_rdy_outs", out_bus(), 13'h1800);
    check("fetch_rdy_retired", retired, exp_retired[7:0]);
    @(negedge clk);
    mem_ready = 1'($urandom); Opcode = op; run = 1'($urandom);
    #1;
    check("decode_state", state, S_DECODE);
    check("decode_outs", out_bus(), 13'h0);
    @(negedge clk);
    mem_ready = 1'($urandom); Opcode = 4'($urandom); Z = z; C = c; run = 1'($urandom);
    #1;
    exp_bus = ref_exec(op, z, c);
    check("exec_state", state, S_EXEC);
    check($sformatf("exec_outs_op%0d_z%0d_c%0d", op, z, c), out_bus(), exp_bus);
    check("exec_retired", retired, exp_retired[7:0]);
    check("exec_inc_load_excl", IncPC & LoadPC, 1'b0);
    if (IncPC) incpc_pulses++;
    exp_retired = (exp_retired + 1) % 256;
`ifdef SINGLE_STEP_EN
    if (op != 4'd15) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        step = 1'b0; mem_ready = 1'($urandom); run = 1'($urandom);
        #1;
        check("stepwait_state", state, S_STEPWAIT);
        check("stepwait_outs", out_bus(), 13'h0);
      end
      @(negedge clk);
      step = 1'b1;
      #1;
      check("stepwait_go_state", state, S_STEPWAIT);
      check("stepwait_go_outs", out_bus(), 13'h0);
      @(negedge clk);
      step = 1'b0;
    end
`else
    if (hold < 0) check("hold_arg", hold, 0);
`endif
  endtask

  initial begin
    CLB = 1'b0; run = 1'b0; Z = 1'b0; C = 1'b0; mem_ready = 1'b0; Opcode = 4'd0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    do_reset();

    // IDLE holds while run is low
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      run = 1'b0; mem_ready = 1'($urandom);
      #1;
      check("idle_hold_state", state, S_IDLE);
      check("idle_hold_outs", out_bus(), 13'h0);
    end

    // ADD with mem_ready on the second FETCH cycle; jump taken / not taken
    start();
    exec_instr(4'b0001, 1'b0, 1'b0, 1, 5);
    exec_instr(4'b0110, 1'b1, 1'b0, 0, 0);
    exec_instr(4'b0110, 1'b0, 1'b1, 2, 1);
    exec_instr(4'b0111, 1'b1, 1'b0, 0, 0);
    exec_instr(4'b1000, 1'b0, 1'b1, 0, 0);
    exec_instr(4'b1010, 1'b1, 1'b0, 0, 0);

    // Reset while FETCH waits on memory
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("midfetch_state", state, S_FETCH);
      check("midfetch_retired", retired, exp_retired[7:0]);
    end
    @(negedge clk);
    CLB = 1'b0; run = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    CLB = 1'b1; run = 1'b0; mem_ready = 1'b0;
    #1;
    check("midfetch_rst_state", state, S_IDLE);
    check("midfetch_rst_mem_req", mem_req, 1'b0);
    check("midfetch_rst_retired", retired, 8'd0);
    exp_retired = 0;

    // Randomized instruction stream
    start();
    for (int n = 0; n < 60; n++) begin
      exec_instr(4'($urandom_range(14, 0)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
    end

    // HALT is sticky and ignores run
    exec_instr(4'b1111, 1'($urandom), 1'($urandom), 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = 1'($urandom); Opcode = 4'($urandom);
      Z = 1'($urandom); C = 1'($urandom);
      #1;
      check("halt_state", state, S_HALT);
      check("halt_halted", halted, 1'b1);
      check("halt_outs", out_bus(), 13'h0);
      check("halt_retired", retired, exp_retired[7:0]);
    end
    do_reset();

    // 256 NOPs wrap the retire counter back to zero
    start();
    incpc_pulses = 0;
    for (int n = 0; n < 256; n++) begin
      case ($urandom_range(2, 0))
        0:       exec_instr(4'b0000, 1'($urandom), 1'($urandom), 0, 0);
        1:       exec_instr(4'b1001, 1'($urandom), 1'($urandom), 0, 0);
        default: exec_instr(4'b1110, 1'($urandom), 1'($urandom), 0, 0);
      endcase
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("wrap_retired", retired, 8'd0);
    check("wrap_incpc_pulses", incpc_pulses, 256);
    check("wrap_state", state, S_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
